adc_frontend: RTL and testbench

ADC_FRONTEND -- requirements
Module: adc_frontend

---
 rtl/wavefe_pkg.sv | 16 +
 rtl/box_sum8.sv | 19 +
 rtl/adc_frontend.sv | 106 ++++++++++
 tb/tb_adc_frontend.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/wavefe_pkg.sv
// wavefe_pkg: shared FSM states, command codes, history geometry and saturating threshold step
package wavefe_pkg;
    typedef enum logic [1:0] {FILL, ARMED, PULSE, HOLDOFF} state_t;
    localparam int DEPTH = 40;
    localparam int WIN = 8;
    localparam logic [7:0] CMD_RELOAD = 8'd1;
    localparam logic [7:0] CMD_UP32 = 8'd16;
    localparam logic [7:0] CMD_DN32 = 8'd17;
    localparam logic [7:0] CMD_UP4 = 8'd18;
    localparam logic [7:0] CMD_DN4 = 8'd19;
    function automatic logic [9:0] sat_add(input logic [9:0] v, input logic signed [6:0] d);
        logic signed [11:0] t;
        t = $signed({2'b00, v}) + 12'(d);
        return t < 12'sd0 ? 10'd0 : t > 12'sd1023 ? 10'd1023 : t[9:0];
    endfunction
endpackage

// File: rtl/box_sum8.sv
// box_sum8: registered 13-bit sum of an eight-sample window
module box_sum8
    import wavefe_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIN-1:0][9:0] x,
    output logic [12:0]         sum
);
    logic [12:0] s;
    always_comb begin
        s = '0;
        for (int i = 0; i < WIN; i++) s = s + 13'(x[i]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum <= '0;
        else sum <= s;
    end
endmodule

// File: rtl/adc_frontend.sv
// adc_frontend: ADC clocking, sample history, decimated averages and pulse-height trigger
module adc_frontend
    import wavefe_pkg::*;
#(
    parameter int DECIM    = 8192,
    parameter int THR_INIT = 540,
    parameter int HOLD     = 16
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [9:0] WAVEX,
    input  logic       OVR,
    output logic       ADCLK,
    input  logic       EN,
    input  logic [7:0] CMD,
    input  logic       CMD_VALID,
    output logic       SAMP_VALID,
    output logic [9:0] SAMP_DATA,
    output logic       TRIG,
    output logic       PEAK_VALID,
    output logic [9:0] PEAK,
    output logic [9:0] THR
);
    localparam int CW = $clog2(DECIM);
    localparam int HW = $clog2(HOLD + 1);
    logic [DEPTH-1:0][9:0] hist;
    logic [12:0] sum0, sum1;
    logic [9:0] avg, base, diff, peak, peak_nx, thr_nx;
    logic [10:0] lim;
    logic over, sen_d, cmp, wrap;
    logic [CW-1:0] cnt;
    logic [5:0] fill_cnt;
    logic [HW-1:0] hold_cnt, hold_nx;
    state_t state, state_nx;
    box_sum8 u_sum0 (.clk(CLK), .rst_n(RSTN), .x(hist[WIN-1:0]), .sum(sum0));
    box_sum8 u_sum1 (.clk(CLK), .rst_n(RSTN), .x(hist[DEPTH-1:DEPTH-WIN]), .sum(sum1));
    assign avg = 10'(sum0 >> 3);
    assign base = 10'(sum1 >> 3);
    assign diff = avg - base;
    assign lim = {1'b0, base} + {1'b0, THR};
    assign over = {1'b0, avg} > lim;
    assign wrap = EN && cnt == CW'(DECIM - 1);
    assign TRIG = state == PULSE;
    assign PEAK = peak;
    // cmp marks the cycle in which the sums first reflect the latest shift
    assign PEAK_VALID = state == PULSE && EN && cmp && !over;
    always_comb begin
        thr_nx = !CMD_VALID ? THR :
                 CMD == CMD_RELOAD ? 10'(THR_INIT) :
                 CMD == CMD_UP32 ? sat_add(THR, 7'sd32) :
                 CMD == CMD_DN32 ? sat_add(THR, -7'sd32) :
                 CMD == CMD_UP4 ? sat_add(THR, 7'sd4) :
                 CMD == CMD_DN4 ? sat_add(THR, -7'sd4) : THR;
    end
    always_comb begin
        state_nx = state;
        peak_nx = peak;
        hold_nx = hold_cnt;
        case (state)
            FILL: if (fill_cnt == 6'(DEPTH)) state_nx = ARMED;
            ARMED: if (EN && cmp && over) begin
                state_nx = PULSE;
                peak_nx = diff;
            end
            PULSE: if (!EN) state_nx = ARMED;
                else if (cmp && over) peak_nx = diff > peak ? diff : peak;
                else if (cmp) begin
                    state_nx = HOLDOFF;
                    hold_nx = '0;
                end
            HOLDOFF: if (!EN) state_nx = ARMED;
                else if (ADCLK && hold_cnt == HW'(HOLD - 1)) state_nx = ARMED;
                else if (ADCLK) hold_nx = hold_cnt + 1'b1;
            default: state_nx = FILL;
        endcase
    end
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ADCLK <= 1'b0;
            sen_d <= 1'b0;
            cmp <= 1'b0;
            hist <= '0;
            cnt <= '0;
            SAMP_VALID <= 1'b0;
            SAMP_DATA <= '0;
            fill_cnt <= '0;
            hold_cnt <= '0;
            state <= FILL;
            peak <= '0;
            THR <= 10'(THR_INIT);
        end else begin
            ADCLK <= !ADCLK;
            sen_d <= ADCLK;
            cmp <= sen_d;
            if (ADCLK) hist <= {hist[DEPTH-2:0], OVR ? 10'd1023 : WAVEX};
            if (ADCLK && fill_cnt != 6'(DEPTH)) fill_cnt <= fill_cnt + 1'b1;
            cnt <= !EN || wrap ? '0 : cnt + 1'b1;
            SAMP_VALID <= wrap;
            if (wrap) SAMP_DATA <= avg;
            hold_cnt <= hold_nx;
            state <= state_nx;
            peak <= peak_nx;
            THR <= thr_nx;
        end
    end
endmodule

// File: tb/tb_adc_frontend.sv
// tb_adc_frontend: directed stimulus with queued peak/sample expectations checked by a monitor
module tb_adc_frontend;
    import wavefe_pkg::*;
    logic CLK = 1'b0;
    logic RSTN, OVR, ADCLK, EN, CMD_VALID, SAMP_VALID, TRIG, PEAK_VALID;
    logic [9:0] WAVEX, SAMP_DATA, PEAK, THR;
    logic [7:0] CMD;
    int checks = 0;
    int failures = 0;
    int peak_q[$];
    int samp_q[$];
    adc_frontend #(.DECIM(16), .THR_INIT(540), .HOLD(16)) dut (
        .CLK(CLK), .RSTN(RSTN), .WAVEX(WAVEX), .OVR(OVR), .ADCLK(ADCLK), .EN(EN),
        .CMD(CMD), .CMD_VALID(CMD_VALID), .SAMP_VALID(SAMP_VALID), .SAMP_DATA(SAMP_DATA),
        .TRIG(TRIG), .PEAK_VALID(PEAK_VALID), .PEAK(PEAK), .THR(THR)
    );
    always #4 CLK = ~CLK;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    // one call = one ADC sample, applied in a cycle where ADCLK is high
    task automatic sample(input int v, input logic o);
        @(negedge CLK);
        if (!ADCLK) @(negedge CLK);
        chk("adclk_sync", ADCLK, 1);
        WAVEX = 10'(v);
        OVR = o;
        @(negedge CLK);
    endtask
    task automatic cmd(input int c);
        @(negedge CLK);
        CMD = 8'(c);
        CMD_VALID = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask
    always @(negedge CLK) begin
        if (PEAK_VALID) begin
            if (peak_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL peak_unexpected: PEAK_VALID with PEAK=%0d, none expected", PEAK);
            end else chk("peak", PEAK, peak_q.pop_front());
        end
        if (SAMP_VALID && samp_q.size() != 0) chk("samp_data", SAMP_DATA, samp_q.pop_front());
    end
    initial begin
        #400000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end
    initial begin
        RSTN = 1'b0; WAVEX = '0; OVR = 1'b0; EN = 1'b0; CMD = '0; CMD_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_adclk", ADCLK, 0);
        chk("rst_thr", THR, 540);
        chk("rst_trig", TRIG, 0);
        chk("rst_samp_valid", SAMP_VALID, 0);
        chk("rst_peak", PEAK, 0);
        chk("rst_state", int'(dut.state), int'(FILL));
        RSTN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("adclk_toggle", ADCLK, (i % 2 == 0) ? 1 : 0);
        end
        EN = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            sample(100, 1'b0);
            if (k == 36) chk("still_fill", int'(dut.state), int'(FILL));
            if (k == 40) chk("armed_after_fill", int'(dut.state), int'(ARMED));
        end
        chk("flat_no_trig", TRIG, 0);
        peak_q.push_back(600);
        for (int k = 1; k <= 20; k++) begin
            sample(700, 1'b0);
            if (k == 8) chk("trig_below_thr", TRIG, 0);
            if (k == 9) chk("trig_rise", TRIG, 1);
        end
        for (int j = 1; j <= 30; j++) begin
            sample((j >= 3 && j <= 14) ? 700 : 100, 1'b0);
            if (j == 12) begin
                chk("holdoff_no_retrig", TRIG, 0);
                chk("holdoff_state", int'(dut.state), int'(HOLDOFF));
            end
        end
        chk("rearmed", int'(dut.state), int'(ARMED));
        repeat (45) sample(100, 1'b0);
        cmd(16);
        chk("thr_up32", THR, 572);
        repeat (39) cmd(16);
        chk("thr_sat_hi", THR, 1023);
        cmd(17);
        chk("thr_dn32", THR, 991);
        repeat (39) cmd(17);
        chk("thr_sat_lo", THR, 0);
        cmd(18);
        chk("thr_up4", THR, 4);
        cmd(7);
        chk("thr_ignore", THR, 4);
        cmd(19);
        cmd(19);
        chk("thr_dn4_sat", THR, 0);
        cmd(1);
        chk("thr_reload", THR, 540);
        cmd(18);
        chk("thr_544", THR, 544);
        EN = 1'b0;
        for (int m = 0; m < 10; m++) sample(8 * m, 1'b0);
        EN = 1'b1;
        samp_q.push_back(100);
        samp_q.push_back(164);
        samp_q.push_back(228);
        samp_q.push_back(292);
        for (int m = 10; m <= 42; m++) sample(8 * m, 1'b0);
        EN = 1'b0;
        chk("samp_all_seen", samp_q.size(), 0);
        repeat (8) sample(100, 1'b0);
        repeat (7) sample(0, 1'b1);
        @(negedge CLK);
        chk("ovr_avg7", int'(dut.avg), 907);
        sample(0, 1'b1);
        @(negedge CLK);
        chk("ovr_avg8", int'(dut.avg), 1023);
        EN = 1'b1;
        sample(0, 1'b1);
        chk("ovr_trig", TRIG, 1);
        RSTN = 1'b0;
        #1;
        chk("mid_rst_trig", TRIG, 0);
        chk("mid_rst_peak", PEAK, 0);
        chk("mid_rst_thr", THR, 540);
        chk("mid_rst_samp", SAMP_DATA, 0);
        chk("mid_rst_state", int'(dut.state), int'(FILL));
        OVR = 1'b0;
        WAVEX = '0;
        @(negedge CLK);
        RSTN = 1'b1;
        repeat (45) sample(100, 1'b0);
        chk("refill_armed", int'(dut.state), int'(ARMED));
        for (int k = 1; k <= 9; k++) sample(700, 1'b0);
        chk("en_drop_trig_before", TRIG, 1);
        EN = 1'b0;
        @(negedge CLK);
        chk("en_drop_trig_after", TRIG, 0);
        chk("en_drop_state", int'(dut.state), int'(ARMED));
        repeat (3) sample(700, 1'b0);
        repeat (12) sample(100, 1'b0);
        chk("en_drop_armed_end", int'(dut.state), int'(ARMED));
        chk("peak_all_seen", peak_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
